// File: rtl/prio_irq_encoder.sv
// Registered priority encoder for active-low request lines with per-channel mask,
// pending latch and a valid/ack handshake toward a single consumer.
module prio_irq_encoder #(
   parameter int N      = 16,
   parameter int CODE_W = 4,
   parameter int EDGE   = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N-1:0]      req_n,
   input  logic [N-1:0]      mask,
   input  logic              clr,
   input  logic              ack_i,
   output logic [CODE_W-1:0] code_o,
   output logic              valid_o,
   output logic [N-1:0]      pend_o
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t              r_state;
   logic [N-1:0]        r_reqQ;
   logic [N-1:0]        r_reqQq;
   logic [N-1:0]        r_pend;
   logic [CODE_W-1:0]   r_code;
   logic                r_valid;

   logic [N-1:0]        w_set;
   logic [N-1:0]        w_elig;
   logic [CODE_W-1:0]   w_sel;
   logic                w_ackHit;

   if ((2 ** CODE_W) < N || N < 2 || N > 64) begin : gBadParams
      $error("prio_irq_encoder: N must be 2..64 and 2**CODE_W >= N");
   end

   if (EDGE != 0) begin : gEdgeSet
      assign w_set = r_reqQq & ~r_reqQ;
   end else begin : gLevelSet
      assign w_set = ~r_reqQ;
   end

   // Selection sees only the registered pending bits, never this cycle's sets.
   assign w_elig   = r_pend & ~mask;
   assign w_ackHit = ack_i & r_valid;

   always_comb begin
      w_sel = '0;
      for (int i = 0; i < N; i++) begin
         if (w_elig[i]) begin
            w_sel = CODE_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_reqQ  <= '1;
         r_reqQq <= '1;
      end else begin
         r_reqQ  <= req_n;
         r_reqQq <= r_reqQ;
      end
   end

   // A new set outranks the ack clear so an edge arriving during service is kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (clr) begin
               r_pend[i] <= 1'b0;
            end else if (w_set[i]) begin
               r_pend[i] <= 1'b1;
            end else if (w_ackHit && (r_code == CODE_W'(i))) begin
               r_pend[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_code  <= '0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!clr && (w_elig != '0)) begin
                  r_code  <= w_sel;
                  r_valid <= 1'b1;
                  r_state <= HOLD;
               end else begin
                  r_valid <= 1'b0;
               end
            end
            HOLD: begin
               if (clr || ack_i) begin
                  r_valid <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign code_o  = r_code;
   assign valid_o = r_valid;
   assign pend_o  = r_pend;

endmodule

// File: tb/tb_prio_irq_encoder.sv
// Directed bench: level-mode instance driven from a vector table, edge-mode instance
// and reset behaviour exercised by hand-written sequences.
module tb_prio_irq_encoder;

   typedef struct {
      logic [15:0] reqN;
      logic [15:0] mask;
      logic        clr;
      logic        ack;
      logic        expValid;
      logic [3:0]  expCode;
      logic [15:0] expPend;
   } vec_t;

   logic        clk;
   logic        rstA_n, rstB_n;
   logic [15:0] reqA, maskA, reqB, maskB;
   logic        clrA, ackA, clrB, ackB;
   logic [3:0]  codeA, codeB;
   logic        validA, validB;
   logic [15:0] pendA, pendB;

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   prio_irq_encoder #(.N(16), .CODE_W(4), .EDGE(0)) dutLevel (
      .clk(clk), .rst_n(rstA_n), .req_n(reqA), .mask(maskA), .clr(clrA),
      .ack_i(ackA), .code_o(codeA), .valid_o(validA), .pend_o(pendA));

   prio_irq_encoder #(.N(16), .CODE_W(4), .EDGE(1)) dutEdge (
      .clk(clk), .rst_n(rstB_n), .req_n(reqB), .mask(maskB), .clr(clrB),
      .ack_i(ackB), .code_o(codeB), .valid_o(validB), .pend_o(pendB));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // sel=0 drives the level-mode instance, sel=1 the edge-mode instance, then one edge
   task automatic applyStimulus(input bit sel, input logic [15:0] reqN, input logic [15:0] m,
                                input logic c, input logic a);
      if (sel) begin
         reqB = reqN; maskB = m; clrB = c; ackB = a;
      end else begin
         reqA = reqN; maskA = m; clrA = c; ackA = a;
      end
      tick();
   endtask

   task automatic checkB(input string name, input logic v, input logic [3:0] code, input logic [15:0] pend);
      checkOutput({name, ".valid"}, 32'(validB), 32'(v));
      checkOutput({name, ".code"}, 32'(codeB), 32'(code));
      checkOutput({name, ".pend"}, 32'(pendB), 32'(pend));
   endtask

   task automatic addVec(input logic [15:0] r, input logic [15:0] m, input logic c, input logic a,
                         input logic v, input logic [3:0] code, input logic [15:0] p);
      vec_t t;
      t.reqN = r; t.mask = m; t.clr = c; t.ack = a;
      t.expValid = v; t.expCode = code; t.expPend = p;
      vecs.push_back(t);
   endtask

   initial begin
      int presents;

      // priority among 3, 9, 14 with level re-set after ack
      addVec(16'hBDF7, 16'h0000, 0, 0, 0, 4'd0,  16'h0000);
      addVec(16'hBDF7, 16'h0000, 0, 0, 0, 4'd0,  16'h4208);
      addVec(16'hBDF7, 16'h0000, 0, 0, 1, 4'd14, 16'h4208);
      addVec(16'hBDF7, 16'h0000, 0, 1, 0, 4'd14, 16'h4208);
      addVec(16'hBDF7, 16'h0000, 0, 0, 1, 4'd14, 16'h4208);
      addVec(16'hFDF7, 16'h0000, 0, 0, 1, 4'd14, 16'h4208);
      addVec(16'hFDF7, 16'h0000, 0, 1, 0, 4'd14, 16'h0208);
      addVec(16'hFDF7, 16'h0000, 0, 0, 1, 4'd9,  16'h0208);
      addVec(16'hFFF7, 16'h0000, 0, 0, 1, 4'd9,  16'h0208);
      addVec(16'hFFF7, 16'h0000, 0, 1, 0, 4'd9,  16'h0008);
      addVec(16'hFFF7, 16'h0000, 0, 0, 1, 4'd3,  16'h0008);
      addVec(16'hFFFF, 16'h0000, 0, 0, 1, 4'd3,  16'h0008);
      addVec(16'hFFFF, 16'h0000, 0, 1, 0, 4'd3,  16'h0000);
      addVec(16'hFFFF, 16'h0000, 0, 0, 0, 4'd3,  16'h0000);
      addVec(16'hFFFF, 16'h0000, 0, 1, 0, 4'd3,  16'h0000);
      // mask and hold on channels 2 and 12
      addVec(16'hEFFB, 16'h1000, 0, 0, 0, 4'd3,  16'h0000);
      addVec(16'hEFFB, 16'h1000, 0, 0, 0, 4'd3,  16'h1004);
      addVec(16'hEFFB, 16'h1000, 0, 0, 1, 4'd2,  16'h1004);
      addVec(16'hEFFB, 16'h0000, 0, 0, 1, 4'd2,  16'h1004);
      addVec(16'hEFFB, 16'hFFFF, 0, 1, 0, 4'd2,  16'h1004);
      addVec(16'hEFFB, 16'hFFFF, 0, 0, 0, 4'd2,  16'h1004);
      addVec(16'hEFFB, 16'hFFFF, 0, 0, 0, 4'd2,  16'h1004);
      addVec(16'hEFFB, 16'h0000, 0, 0, 1, 4'd12, 16'h1004);
      addVec(16'hFFFF, 16'h0000, 1, 0, 0, 4'd12, 16'h0000);
      addVec(16'hFFFF, 16'h0000, 0, 0, 0, 4'd12, 16'h0000);
      // clr together with ack and a new set on channel 4
      addVec(16'hEFFF, 16'h0000, 0, 0, 0, 4'd12, 16'h0000);
      addVec(16'hEFFF, 16'h0000, 0, 0, 0, 4'd12, 16'h1000);
      addVec(16'hEFFF, 16'h0000, 0, 0, 1, 4'd12, 16'h1000);
      addVec(16'hEFEF, 16'h0000, 0, 0, 1, 4'd12, 16'h1000);
      addVec(16'hFFFF, 16'h0000, 1, 1, 0, 4'd12, 16'h0000);
      addVec(16'hFFFF, 16'h0000, 0, 0, 0, 4'd12, 16'h0000);

      reqA = '1; maskA = '0; clrA = 0; ackA = 0; rstA_n = 0;
      reqB = '1; maskB = '0; clrB = 0; ackB = 0; rstB_n = 0;
      tick();
      tick();
      checkOutput("resetA.valid", 32'(validA), 32'h0);
      checkOutput("resetA.code", 32'(codeA), 32'h0);
      checkOutput("resetA.pend", 32'(pendA), 32'h0);
      checkB("resetB", 0, 4'd0, 16'h0000);
      rstA_n = 1; rstB_n = 1;
      tick();

      foreach (vecs[i]) begin
         applyStimulus(0, vecs[i].reqN, vecs[i].mask, vecs[i].clr, vecs[i].ack);
         checkOutput($sformatf("vec%0d.valid", i), 32'(validA), 32'(vecs[i].expValid));
         checkOutput($sformatf("vec%0d.code", i), 32'(codeA), 32'(vecs[i].expCode));
         checkOutput($sformatf("vec%0d.pend", i), 32'(pendA), 32'(vecs[i].expPend));
      end

      // edge mode: one-cycle pulse on channel 7, no re-presentation after ack
      applyStimulus(1, 16'hFF7F, 16'h0000, 0, 0); checkB("pulse0", 0, 4'd0, 16'h0000);
      applyStimulus(1, 16'hFFFF, 16'h0000, 0, 0); checkB("pulse1", 0, 4'd0, 16'h0080);
      applyStimulus(1, 16'hFFFF, 16'h0000, 0, 0); checkB("pulse2", 1, 4'd7, 16'h0080);
      applyStimulus(1, 16'hFFFF, 16'h0000, 0, 1); checkB("pulse3", 0, 4'd7, 16'h0000);
      applyStimulus(1, 16'hFFFF, 16'h0000, 0, 0); checkB("pulse4", 0, 4'd7, 16'h0000);
      applyStimulus(1, 16'hFFFF, 16'h0000, 0, 0); checkB("pulse5", 0, 4'd7, 16'h0000);

      // edge mode: channel 7 held low for 10 cycles with ack always high
      presents = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, 16'hFF7F, 16'h0000, 0, 1);
         if (validB) presents++;
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 16'hFFFF, 16'h0000, 0, 1);
         if (validB) presents++;
      end
      checkOutput("held.presentations", 32'(presents), 32'd1);
      applyStimulus(1, 16'hFFFF, 16'h0000, 0, 0); checkB("held.after", 0, 4'd7, 16'h0000);

      // edge mode: fresh falling edge lands on the same edge as the ack of code 7
      applyStimulus(1, 16'hFF7F, 16'h0000, 0, 0); checkB("coll0", 0, 4'd7, 16'h0000);
      applyStimulus(1, 16'hFFFF, 16'h0000, 0, 0); checkB("coll1", 0, 4'd7, 16'h0080);
      applyStimulus(1, 16'hFFFF, 16'h0000, 0, 0); checkB("coll2", 1, 4'd7, 16'h0080);
      applyStimulus(1, 16'hFF7F, 16'h0000, 0, 0); checkB("coll3", 1, 4'd7, 16'h0080);
      applyStimulus(1, 16'hFFFF, 16'h0000, 0, 1); checkB("coll4", 0, 4'd7, 16'h0080);
      applyStimulus(1, 16'hFFFF, 16'h0000, 0, 0); checkB("coll5", 1, 4'd7, 16'h0080);
      applyStimulus(1, 16'hFFFF, 16'h0000, 0, 1); checkB("coll6", 0, 4'd7, 16'h0000);
      applyStimulus(1, 16'hFFFF, 16'h0000, 0, 0); checkB("coll7", 0, 4'd7, 16'h0000);

      // async reset in the middle of presenting channel 5
      applyStimulus(0, 16'hFFDF, 16'h0000, 0, 0);
      applyStimulus(0, 16'hFFDF, 16'h0000, 0, 0);
      checkOutput("rst.pre.valid", 32'(validA), 32'h0);
      applyStimulus(0, 16'hFFDF, 16'h0000, 0, 0);
      checkOutput("rst.pre.valid3", 32'(validA), 32'h1);
      checkOutput("rst.pre.code3", 32'(codeA), 32'h5);
      rstA_n = 0;
      #1;
      checkOutput("rst.async.valid", 32'(validA), 32'h0);
      checkOutput("rst.async.code", 32'(codeA), 32'h0);
      checkOutput("rst.async.pend", 32'(pendA), 32'h0);
      tick();
      checkOutput("rst.held.valid", 32'(validA), 32'h0);
      rstA_n = 1;
      tick();
      checkOutput("rst.e1.pend", 32'(pendA), 32'h0);
      tick();
      checkOutput("rst.e2.valid", 32'(validA), 32'h0);
      checkOutput("rst.e2.pend", 32'(pendA), 32'h0020);
      tick();
      checkOutput("rst.e3.valid", 32'(validA), 32'h1);
      checkOutput("rst.e3.code", 32'(codeA), 32'h5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/prio_irq_encoder.md
Name: prio_irq_encoder

Overview:
- Parametrised, registered successor to the team's active-low priority encoder: N active-low request lines, per-channel mask, pending latch, and a valid/ack handshake.
- The highest-index pending, unmasked channel is encoded and held on code_o until the consumer acknowledges it.
- Sits between raw active-low request pins (or peripheral flags) and a single-consumer service unit such as a CPU interrupt port or DMA scheduler.

Parameters:
N, 16, number of request channels (2..64).
CODE_W, 4, width of code_o; must satisfy 2**CODE_W >= N (elaboration-time check).
EDGE, 0, 0 = level mode (pending set while request low); 1 = edge mode (pending set on high-to-low transition).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req_n  input  N  active-low requests; bit i = channel i; higher index = higher priority.
mask  input  N  1 = channel excluded from selection; it still latches into pending.
clr  input  1  synchronous clear of all pending bits and any presented code.
ack_i  input  1  consumer accepts the presented code; effective only when valid_o=1.
code_o  output  CODE_W  index of the selected channel; valid only when valid_o=1.
valid_o  output  1  code_o holds a selected channel awaiting ack.
pend_o  output  N  current pending register (debug/status).

Behaviour:
- Reset (rst_n low, async): req_q and req_qq all ones; pend=0; valid_o=0; code_o=0; state IDLE. Outputs stay there until the first rising edge after rst_n deasserts.
- Input stage, every edge: req_q<=req_n; req_qq<=req_q. Single sample stage only; the block does not synchronise asynchronous pins for metastability.
- Set event, channel i:
  - EDGE=0: set_i = ~req_q[i].
  - EDGE=1: set_i = req_qq[i] & ~req_q[i].
- Pending update, every edge, per bit. Priority order:
  1. clr=1 -> pend[i]<=0. clr beats set in the same cycle.
  2. set_i=1 -> pend[i]<=1. Set beats a simultaneous ack clear, so a new edge is never lost.
  3. ack_i & valid_o & code_o==i -> pend[i]<=0.
  4. Otherwise hold.
- Eligible vector: elig = pend & ~mask, using the registered pend only (not the same-cycle set).
- Selection: sel = highest i with elig[i]=1.
- State machine, 2 states:
  - IDLE: if clr=0 and elig!=0, then code_o<=sel, valid_o<=1, go HOLD. Else valid_o=0 and code_o holds its last value.
  - HOLD: code_o and valid_o are frozen. Mask changes, new higher-priority sets, and the presented channel's own pend bit do not alter them.
    - ack_i=1 -> valid_o<=0, go IDLE.
    - clr=1 -> valid_o<=0, go IDLE. clr beats ack.
  - After an ack there is always one IDLE cycle (valid_o=0) before the next code is presented. Max throughput is one code per 2 cycles.
- ack_i while valid_o=0 is ignored.
- Latency: a request first sampled low at edge E0 sets req_q. pend is set at E1 (EDGE=1 needs req_qq=1 at E0). valid_o rises at E2.
- Level mode, request still low at ack: pend re-sets on the same edge (rule 2), and the channel is presented again after the bubble cycle.
- All channels masked with pend nonzero: valid_o stays 0 and pend_o shows the latched bits. Unmasking re-enables presentation on the next IDLE edge.
- Width rules: code_o is the zero-extended index; sel is computed combinationally from elig by a parametrised loop.

Test Plan:
- Reset mid-operation: N=16, EDGE=0, req_n[5]=0, valid_o=1 code_o=5, then assert rst_n=0 -> valid_o=0, code_o=0, pend_o=0 immediately (async). After release with req_n[5] still 0 -> valid_o=1 code_o=5 at the 3rd edge.
- Priority: EDGE=0, req_n bits 3, 9, 14 low -> code_o=14. ack -> one bubble cycle, then code_o=14 again (level re-sets). Release bit 14 before ack -> after ack code_o=9, then 3.
- Edge mode: EDGE=1, pulse req_n[7] low for 1 cycle -> pend_o[7]=1, code_o=7. ack -> pend_o=0 and no re-presentation. Hold req_n[7] low for 10 cycles -> exactly one presentation.
- Ack/set collision: EDGE=1, new falling edge on channel 7 registered on the same edge as ack of code 7 -> pend_o[7] stays 1 and code 7 is presented again after the bubble.
- Mask and hold: pend bits 2 and 12 set, mask[12]=1 -> code_o=2. Unmask 12 while in HOLD -> code_o stays 2 until ack, then 12. Mask all bits -> valid_o=0 while pend_o stays 0x1004.
- Clear: valid_o=1 code_o=12, then clr=1 together with ack_i=1 and a new set on channel 4 -> pend_o=0, valid_o=0 on the next edge, and channel 4 is not latched.
